pwm8_demo_top: RTL and testbench

// - Self-running demonstration/test top for the 8-bit PWM peripheral: scripted sequencer loads duty values into

---
 rtl/pwm8_demo_pkg.sv | 37 +++
 rtl/pwm8_demo_top_channel.sv | 57 +++++
 rtl/pwm8_demo_top.sv | 160 ++++++++++++++++
 tb/tb_pwm8_demo_top.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pwm8_demo_pkg.sv
// Shared constants, sequencer state type and the duty script for the 8-bit PWM demo.
package pwm8_demo_pkg;

    localparam int PWM_PERIOD  = 255;
    localparam int WRITE_PHASE = 127;
    localparam int NUM_STEPS   = 5;
    localparam int NUM_MULTI   = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_HOLD,
        ST_DONE
    } seq_state_t;

    typedef struct packed {
        logic [7:0]                 duty_s;
        logic [NUM_MULTI-1:0][7:0]  duty_m;
        logic [3:0]                 hold;
    } step_t;

    // duty_m is packed as {multi[2], multi[1], multi[0]}
    localparam step_t SCRIPT [NUM_STEPS] = '{
        '{duty_s: 8'h00, duty_m: {8'h00, 8'h00, 8'h00}, hold: 4'd2},
        '{duty_s: 8'h80, duty_m: {8'hFF, 8'h40, 8'h00}, hold: 4'd2},
        '{duty_s: 8'hFF, duty_m: {8'hFE, 8'h80, 8'h01}, hold: 4'd2},
        '{duty_s: 8'h01, duty_m: {8'h80, 8'h00, 8'hFF}, hold: 4'd2},
        '{duty_s: 8'h00, duty_m: {8'h00, 8'h00, 8'h00}, hold: 4'd1}
    };

    function automatic int prescale_div(input int clk_hz, input int tick_hz);
        int ratio;
        ratio = clk_hz / tick_hz;
        return (ratio < 1) ? 1 : ratio;
    endfunction

endpackage

// File: rtl/pwm8_demo_top_channel.sv
// One PWM compare channel driven by the shared period counter.
// G_NORUNT defers new duties to the period start; G_INVERT flips the registered output.
module pwm8_channel
    import pwm8_demo_pkg::*;
#(
    parameter bit G_NORUNT = 1'b0,
    parameter bit G_INVERT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [7:0] count,
    input  logic       wr,
    input  logic [7:0] duty,
    output logic       pwm
);

    logic [7:0] duty_pend;
    logic [7:0] duty_cmp;

    // Writes are only meaningful on a count step, so they are qualified by tick
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_pend <= 8'd0;
        end else if (wr && tick) begin
            duty_pend <= duty;
        end
    end

    generate
        if (G_NORUNT) begin : g_norunt
            logic [7:0] duty_act;

            // Promote the pending duty on the step that wraps the counter back to 0
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    duty_act <= 8'd0;
                end else if (tick && (count == 8'(PWM_PERIOD - 1))) begin
                    duty_act <= duty_pend;
                end
            end

            assign duty_cmp = duty_act;
        end else begin : g_runt
            assign duty_cmp = duty_pend;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm <= G_INVERT;
        end else begin
            pwm <= (count < duty_cmp) ^ G_INVERT;
        end
    end

endmodule

// File: rtl/pwm8_demo_top.sv
// Self-running PWM demo: prescaler, shared 0..254 period counter, scripted sequencer
// and six compare channels (runt, no-runt, inverted no-runt, three-channel bank).
module pwm8_demo_top
    import pwm8_demo_pkg::*;
#(
    parameter int G_CLK_FREQ_HZ = 100_000_000,
    parameter int G_PWM_TICK_HZ = 10_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic       o_pwm_sr,
    output logic       o_pwm_sn,
    output logic       o_pwm_si,
    output logic [2:0] o_pwm_multi,
    output logic       o_done
);

    localparam int PRESCALE = prescale_div(G_CLK_FREQ_HZ, G_PWM_TICK_HZ);
    localparam int PRESC_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;
    logic [7:0]         count;
    logic               phase_tick;
    logic               wrap_tick;

    seq_state_t state;
    seq_state_t state_next;
    logic [2:0] step_idx;
    logic [3:0] hold_cnt;
    logic       wr;
    logic       hold_dec;
    logic       step_inc;
    step_t      cur_step;

    assign tick       = (presc_cnt == PRESC_W'(PRESCALE - 1));
    assign phase_tick = tick && (count == 8'(WRITE_PHASE - 1));
    assign wrap_tick  = tick && (count == 8'(PWM_PERIOD - 1));
    assign cur_step   = SCRIPT[step_idx];

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            count <= 8'd0;
        end else if (tick) begin
            count <= (count == 8'(PWM_PERIOD - 1)) ? 8'd0 : count + 8'd1;
        end
    end

    // The write lands on the step that brings the counter to WRITE_PHASE, mid-period
    always_comb begin
        state_next = state;
        wr         = 1'b0;
        hold_dec   = 1'b0;
        step_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (phase_tick) begin
                    wr         = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (wrap_tick) begin
                    if (hold_cnt == 4'd1) begin
                        if (step_idx == 3'(NUM_STEPS - 1)) begin
                            state_next = ST_DONE;
                        end else begin
                            step_inc   = 1'b1;
                            state_next = ST_WRITE;
                        end
                    end else begin
                        hold_dec = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state    <= ST_IDLE;
            step_idx <= 3'd0;
            hold_cnt <= 4'd0;
            o_done   <= 1'b0;
        end else begin
            state <= state_next;
            if (wr) begin
                hold_cnt <= cur_step.hold;
            end else if (hold_dec) begin
                hold_cnt <= hold_cnt - 4'd1;
            end
            if (step_inc) begin
                step_idx <= step_idx + 3'd1;
            end
            o_done <= (state_next == ST_DONE);
        end
    end

    pwm8_channel #(.G_NORUNT(1'b0), .G_INVERT(1'b0)) u_sr (
        .clk   (i_clk),
        .rst_n (i_rst),
        .tick  (tick),
        .count (count),
        .wr    (wr),
        .duty  (cur_step.duty_s),
        .pwm   (o_pwm_sr)
    );

    pwm8_channel #(.G_NORUNT(1'b1), .G_INVERT(1'b0)) u_sn (
        .clk   (i_clk),
        .rst_n (i_rst),
        .tick  (tick),
        .count (count),
        .wr    (wr),
        .duty  (cur_step.duty_s),
        .pwm   (o_pwm_sn)
    );

    pwm8_channel #(.G_NORUNT(1'b1), .G_INVERT(1'b1)) u_si (
        .clk   (i_clk),
        .rst_n (i_rst),
        .tick  (tick),
        .count (count),
        .wr    (wr),
        .duty  (cur_step.duty_s),
        .pwm   (o_pwm_si)
    );

    for (genvar i = 0; i < NUM_MULTI; i++) begin : g_multi
        pwm8_channel #(.G_NORUNT(1'b1), .G_INVERT(1'b0)) u_multi (
            .clk   (i_clk),
            .rst_n (i_rst),
            .tick  (tick),
            .count (count),
            .wr    (wr),
            .duty  (cur_step.duty_m[i]),
            .pwm   (o_pwm_multi[i])
        );
    end

endmodule

// File: tb/tb_pwm8_demo_top.sv
// Scoreboard bench for pwm8_demo_top: expected output vectors come from an arithmetic
// timeline of the script and are checked at selected clock edges after reset release.
module tb_pwm8_demo_top;

    localparam int CLKS_PER_TICK = 10;
    localparam int PERIOD_TICKS  = 255;
    localparam int FIRST_WRITE   = 127;
    localparam int STEP_TICKS    = 2 * PERIOD_TICKS;
    localparam int DONE_TICK     = FIRST_WRITE + 4 * STEP_TICKS + (PERIOD_TICKS - FIRST_WRITE);
    localparam logic [6:0] RESET_VEC = 7'b0_000_1_0_0;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       o_pwm_sr;
    logic       o_pwm_sn;
    logic       o_pwm_si;
    logic [2:0] o_pwm_multi;
    logic       o_done;

    always #5 i_clk = ~i_clk;

    pwm8_demo_top dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .o_pwm_sr    (o_pwm_sr),
        .o_pwm_sn    (o_pwm_sn),
        .o_pwm_si    (o_pwm_si),
        .o_pwm_multi (o_pwm_multi),
        .o_done      (o_done)
    );

    typedef struct {
        int         edge_idx;
        string      tag;
        logic [6:0] expected;
    } sb_entry_t;

    sb_entry_t sb[$];
    int tests_run    = 0;
    int tests_failed = 0;
    int edge_idx     = -1;

    int duty_s_tab [5] = '{8'h00, 8'h80, 8'hFF, 8'h01, 8'h00};
    int duty_m_tab [5][3] = '{
        '{8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h40, 8'hFF},
        '{8'h01, 8'h80, 8'hFE},
        '{8'hFF, 8'h00, 8'h80},
        '{8'h00, 8'h00, 8'h00}
    };

    int edges_a [] = '{0, 5, 1269, 1270, 6369, 6370, 6379, 6380, 7649, 7650,
                       8289, 8290, 8929, 8930, 11469, 11470, 12749, 12750,
                       12759, 12760, 13990};
    int edges_b [] = '{0, 5, 1269, 1270, 6369, 6370, 6379, 6380, 7649, 7650,
                       8289, 8290, 8929, 8930, 12749, 12750, 12759, 12760,
                       16569, 16570, 17849, 17850, 17859, 17860, 20669, 20670,
                       22948, 22949, 22950, 23500};

    // Expected {done, multi[2:0], si, sn, sr} observed just after edge e
    function automatic logic [6:0] model_at(input int e);
        int         t;
        int         cnt;
        int         sd;
        int         ad;
        int         am [3];
        logic [2:0] m;
        logic       sn;
        logic       done;
        t   = e / CLKS_PER_TICK;
        cnt = t % PERIOD_TICKS;
        sd  = 0;
        ad  = 0;
        am  = '{0, 0, 0};
        for (int k = 0; k < 5; k++) begin
            if (t >= FIRST_WRITE + STEP_TICKS * k) sd = duty_s_tab[k];
            if (t >= PERIOD_TICKS + STEP_TICKS * k) begin
                ad = duty_s_tab[k];
                for (int i = 0; i < 3; i++) am[i] = duty_m_tab[k][i];
            end
        end
        sn = (cnt < ad);
        for (int i = 0; i < 3; i++) m[i] = (cnt < am[i]);
        done = (((e + 1) / CLKS_PER_TICK) >= DONE_TICK);
        return {done, m, ~sn, sn, (cnt < sd)};
    endfunction

    task automatic check_output(input string tag, input logic [6:0] expected);
        logic [6:0] observed;
        observed = {o_done, o_pwm_multi, o_pwm_si, o_pwm_sn, o_pwm_sr};
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic push_expect(input string phase, input int e);
        sb_entry_t entry;
        entry.edge_idx = e;
        entry.tag      = $sformatf("%s_e%0d", phase, e);
        entry.expected = model_at(e);
        sb.push_back(entry);
    endtask

    task automatic apply_stimulus(input int last_edge);
        sb_entry_t entry;
        while (edge_idx < last_edge) begin
            @(posedge i_clk);
            edge_idx++;
            #1;
            while (sb.size() > 0 && sb[0].edge_idx == edge_idx) begin
                entry = sb.pop_front();
                check_output(entry.tag, entry.expected);
            end
        end
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (cycles) begin
            @(posedge i_clk);
            #1;
            check_output("reset", RESET_VEC);
        end
        @(negedge i_clk);
        i_rst    = 1'b1;
        edge_idx = -1;
    endtask

    initial begin
        i_rst = 1'b0;
        apply_reset(5);
        foreach (edges_a[i]) push_expect("run1", edges_a[i]);
        apply_stimulus(14000);

        apply_reset(3);
        sb.delete();
        foreach (edges_b[i]) push_expect("run2", edges_b[i]);
        apply_stimulus(23500);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
